hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Control partner of the four pipeline register bars: reads the IF/ID, ID/EX and EX/MEM outputs and
//  produces the per-bar enable/flush controls and the PC enable. Detects load-use hazards, squashes
//  wrong-path instructions on jumps and taken branches, freezes the pipe on data-memory misses and
//  latches halt. Sits beside the datapath between the bars and the PC.
// PARAMETERS
//  CNT_W   32   width of the stall-cycle performance counter
// PORTS
//  CLK         in   1      system clock, all state on rising edge
//  RST         in   1      synchronous reset, active-high
//  ihit        in   1      instruction fetch completed this cycle
//  dhit        in   1      data access in MEM completed this cycle
//  id_rs       in   5      rs field of IF/ID instruction
//  id_rt       in   5      rt field of IF/ID instruction
//  id_uses_rt  in   1      IF/ID instruction reads rt as a source
//  ex_dREN     in   1      ID/EX dREN output (load in EX)
//  ex_wsel     in   5      destination register of instruction in EX
//  ex_jump     in   1      j/jal/JR resolved in EX
//  mem_dREN    in   1      EX/MEM dREN output
//  mem_dWEN    in   1      EX/MEM dWEN output
//  mem_brtaken in   1      (beq&zero)|(bne&!zero) from EX/MEM outputs
//  wb_halt     in   1      MEM/WB halt output
//  pc_en       out  1      PC update enable
//  en_1..en_4  out  1 ea   enable of bar 1 (IF/ID) .. bar 4 (MEM/WB)
//  flush_1..3  out  1 ea   load bubble (all-zero controls) into bar 1..3 on the edge
//  halted      out  1      pipeline halted, sticky
//  stall_cnt   out  CNT_W  cycles with pc_en==0 since reset
// BEHAVIOUR
//  - Clock CLK; reset RST is synchronous and active-high. Outputs combinational from state + inputs.
//  - FSM states RUN, MEMWAIT, HALT. Reset -> RUN, stall_cnt=0. While RST=1: all en*=0, pc_en=0,
//    flush_1..3=1, halted=0.
//  - Default (no event): pc_en=1, en_1..4=1, flush_*=0.
//  - Priority in RUN, highest first; only the highest applies:
//    1 wb_halt=1: all enables 0, next state HALT.
//    2 memory freeze: (mem_dREN|mem_dWEN)&!dhit -> pc_en=en_1..4=0, next MEMWAIT.
//    3 mem_brtaken: enables 1, pc_en=1, flush_1=flush_2=flush_3=1 (squash 3 younger).
//    4 ex_jump: enables 1, pc_en=1, flush_1=flush_2=1.
//    5 load-use: ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | id_uses_rt & ex_wsel==id_rt)
//      -> pc_en=0, en_1=0, flush_2=1; bars 3,4 advance. Lasts exactly one cycle per hazard.
//    6 !ihit: pc_en=0, flush_1=1; bars 2-4 advance.
//  - MEMWAIT: pc_en=en_1..4=0 while !dhit. On dhit: default outputs, next RUN. wb_halt ignored here
//    (cannot change, pipe frozen).
//  - HALT: all enables 0, flushes 0, halted=1; exits only via RST.
//  - Branch/jump redirect asserts pc_en even if !ihit (fetch discarded).
//  - Register $0 never creates a load-use hazard.
//  - stall_cnt: +1 on each edge where pc_en==0 in RUN/MEMWAIT (not during RST); saturates at
//    all-ones; holds in HALT.
//  - RST mid-MEMWAIT or in HALT: RUN on next edge, counter cleared.
// TESTING
//  - Load-use: ex_dREN=1, ex_wsel=5, id_rs=5 -> one cycle pc_en=0,en_1=0,flush_2=1; then default.
//  - $0 case: ex_dREN=1, ex_wsel=0, id_rs=0 -> no stall, stall_cnt unchanged.
//  - Branch beats load-use: mem_brtaken=1 with load-use true -> flush_1..3=1, pc_en=1, no stall.
//  - Miss: mem_dREN=1, dhit=0 for 3 cycles then 1 -> 3 frozen cycles then RUN; stall_cnt=3.
//  - Halt: wb_halt=1 -> next cycle halted=1, all en=0; inputs toggled 10 cycles, no change; RST clears.
//  - Reset in MEMWAIT: RST=1 one cycle -> state RUN, stall_cnt=0, default outputs after RST drops.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline bar enable/flush and PC-enable control. Ports: CLK/RST (sync, active-high), hit and hazard inputs from the bars, pc_en, en_1..en_4, flush_1..flush_3, halted, stall_cnt.
module hazard_stall_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_jump,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_brtaken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             en_1,
  output logic             en_2,
  output logic             en_3,
  output logic             en_4,
  output logic             flush_1,
  output logic             flush_2,
  output logic             flush_3,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;
  state_t state, next;
  logic [3:0] en;
  logic [2:0] fl;
  logic load_use, lu_hit, lu_q;
  assign load_use = ex_dREN && ex_wsel != 5'd0 &&
                    (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt));
  assign {en_4, en_3, en_2, en_1} = en;
  assign {flush_3, flush_2, flush_1} = fl;
  // lu_q masks the load-use stall on the cycle after one was taken, so a
  // hazard stalls exactly once even if the inputs do not change.
  always_comb begin
    next = state;
    pc_en = 1'b1;
    en = 4'hf;
    fl = 3'b000;
    halted = 1'b0;
    lu_hit = 1'b0;
    if (RST) begin
      pc_en = 1'b0;
      en = 4'h0;
      fl = 3'b111;
      next = RUN;
    end else if (state == HALT) begin
      pc_en = 1'b0;
      en = 4'h0;
      halted = 1'b1;
    end else if (state == MEMWAIT) begin
      pc_en = dhit;
      en = dhit ? 4'hf : 4'h0;
      next = dhit ? RUN : MEMWAIT;
    end else if (wb_halt) begin
      pc_en = 1'b0;
      en = 4'h0;
      next = HALT;
    end else if ((mem_dREN || mem_dWEN) && !dhit) begin
      pc_en = 1'b0;
      en = 4'h0;
      next = MEMWAIT;
    end else if (mem_brtaken) begin
      fl = 3'b111;
    end else if (ex_jump) begin
      fl = 3'b011;
    end else if (load_use && !lu_q) begin
      pc_en = 1'b0;
      en = 4'b1110;
      fl = 3'b010;
      lu_hit = 1'b1;
    end else if (!ihit) begin
      pc_en = 1'b0;
      fl = 3'b001;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      lu_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= next;
      lu_q <= lu_hit;
      if (state != HALT && !pc_en && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: scoreboard bench with directed and random stimulus against a behavioural model.
module tb_hazard_stall_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst, ihit, dhit, id_uses_rt, ex_dREN, ex_jump, mem_dREN, mem_dWEN, mem_brtaken, wb_halt;
  logic [4:0] id_rs, id_rt, ex_wsel;
  logic pc_en, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3, halted;
  logic [W-1:0] stall_cnt;
  typedef struct {
    logic [8:0] o;
    int         cnt;
    string      tag;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [8:0] act;
  int checks = 0, failures = 0;
  string tag = "init";
  int m_mode = 0;
  int m_cnt = -1;
  bit m_lu = 0;

  hazard_stall_ctrl #(.CNT_W(W)) dut (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_jump(ex_jump),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_brtaken(mem_brtaken), .wb_halt(wb_halt),
    .pc_en(pc_en), .en_1(en_1), .en_2(en_2), .en_3(en_3), .en_4(en_4),
    .flush_1(flush_1), .flush_2(flush_2), .flush_3(flush_3), .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {pc_en, en_4, en_3, en_2, en_1, flush_3, flush_2, flush_1, halted};
      checks++;
      if (act !== e.o) begin
        failures++;
        $display("FAIL %s ctrl {pc,en4..1,fl3..1,halted} got=%b exp=%b", e.tag, act, e.o);
      end
      if (e.cnt >= 0) begin
        checks++;
        if (stall_cnt !== W'(e.cnt)) begin
          failures++;
          $display("FAIL %s stall_cnt got=%0d exp=%0d", e.tag, stall_cnt, e.cnt);
        end
      end
    end
  end

  task automatic idle();
    rst = 0; ihit = 1; dhit = 1; id_uses_rt = 0; ex_dREN = 0; ex_jump = 0;
    mem_dREN = 0; mem_dWEN = 0; mem_brtaken = 0; wb_halt = 0;
    id_rs = 0; id_rt = 0; ex_wsel = 0;
  endtask

  task automatic rnd();
    rst = ($urandom_range(0, 59) == 0);
    ihit = ($urandom_range(0, 4) != 0);
    dhit = ($urandom_range(0, 2) != 0);
    id_uses_rt = $urandom_range(0, 1);
    ex_dREN = $urandom_range(0, 1);
    ex_jump = ($urandom_range(0, 7) == 0);
    mem_dREN = ($urandom_range(0, 5) == 0);
    mem_dWEN = ($urandom_range(0, 7) == 0);
    mem_brtaken = ($urandom_range(0, 7) == 0);
    wb_halt = ($urandom_range(0, 79) == 0);
    id_rs = 5'($urandom_range(0, 3));
    id_rt = 5'($urandom_range(0, 3));
    ex_wsel = 5'($urandom_range(0, 3));
  endtask

  // Expected outputs for the current inputs, then advance the model across the edge.
  task automatic cycle();
    logic pc, h;
    logic [3:0] en;
    logic [2:0] fl;
    bit hz, took_lu;
    int nmode;
    exp_t x;
    hz = ex_dREN && ex_wsel != 0 && (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt));
    pc = 1; en = 4'hf; fl = 3'b000; h = 0; took_lu = 0; nmode = m_mode;
    if (rst) begin pc = 0; en = 0; fl = 3'b111; end
    else if (m_mode == 2) begin pc = 0; en = 0; h = 1; end
    else if (m_mode == 1) begin
      if (!dhit) begin pc = 0; en = 0; end else nmode = 0;
    end
    else if (wb_halt) begin pc = 0; en = 0; nmode = 2; end
    else if ((mem_dREN || mem_dWEN) && !dhit) begin pc = 0; en = 0; nmode = 1; end
    else if (mem_brtaken) fl = 3'b111;
    else if (ex_jump) fl = 3'b011;
    else if (hz && !m_lu) begin pc = 0; en = 4'b1110; fl = 3'b010; took_lu = 1; end
    else if (!ihit) begin pc = 0; fl = 3'b001; end
    x.o = {pc, en, fl, h};
    x.cnt = m_cnt;
    x.tag = tag;
    q.push_back(x);
    if (rst) begin m_mode = 0; m_cnt = 0; m_lu = 0; end
    else begin
      m_lu = took_lu;
      if (m_mode != 2 && !pc && m_cnt >= 0 && m_cnt < (1 << W) - 1) m_cnt++;
      m_mode = nmode;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    tag = "reset"; rst = 1; cycle(); cycle();
    tag = "default"; idle(); cycle();
    tag = "load_use_rs"; ex_dREN = 1; ex_wsel = 5; id_rs = 5; cycle(); cycle();
    idle(); cycle();
    tag = "zero_reg"; ex_dREN = 1; ex_wsel = 0; id_rs = 0; cycle(); idle(); cycle();
    tag = "load_use_rt"; ex_dREN = 1; ex_wsel = 7; id_rt = 7; id_rs = 1; id_uses_rt = 1; cycle();
    idle(); cycle();
    tag = "rt_unused"; ex_dREN = 1; ex_wsel = 7; id_rt = 7; id_rs = 1; cycle(); idle();
    tag = "branch_over_lu"; ex_dREN = 1; ex_wsel = 5; id_rs = 5; mem_brtaken = 1; cycle(); idle();
    tag = "jump_no_ihit"; ex_jump = 1; ihit = 0; cycle(); idle();
    tag = "ifetch_miss"; ihit = 0; cycle(); idle();
    tag = "reset2"; rst = 1; cycle(); idle();
    tag = "dmiss"; mem_dREN = 1; dhit = 0; repeat (3) cycle();
    dhit = 1; cycle(); idle(); cycle();
    tag = "rst_in_memwait"; mem_dWEN = 1; dhit = 0; cycle(); cycle();
    rst = 1; cycle(); idle(); cycle(); cycle();
    tag = "halt"; wb_halt = 1; cycle();
    for (int i = 0; i < 10; i++) begin rnd(); rst = 0; cycle(); end
    tag = "halt_rst"; idle(); rst = 1; cycle(); idle(); cycle();
    tag = "saturate"; ihit = 0; repeat (20) cycle(); idle(); cycle();
    tag = "random";
    for (int i = 0; i < 1500; i++) begin rnd(); cycle(); end
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
